load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between a pipeline and a single-port synchronous data memory.
// Sub-word stores use a read-modify-write sequence; misaligned or out-of-range requests are rejected.
module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        misaligned;
  logic        req_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic [31:0] merged;

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
    req_err = misaligned || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
  end

  // Lane extraction for loads and lane merge for sub-word stores share the captured word.
  always_comb begin
    ld_byte = mem_read_data[7:0];
    case (addr_q[1:0])
      2'd0: ld_byte = mem_read_data[7:0];
      2'd1: ld_byte = mem_read_data[15:8];
      2'd2: ld_byte = mem_read_data[23:16];
      2'd3: ld_byte = mem_read_data[31:24];
      default: ld_byte = mem_read_data[7:0];
    endcase
    ld_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (size_q)
      2'b00:   ld_val = {{24{sgn_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{16{sgn_q & ld_half[15]}}, ld_half};
      default: ld_val = mem_read_data;
    endcase

    merged = mem_read_data;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = mem_read_data;
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          size_d  = req_size;
          sgn_d   = req_signed;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_err) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (req_we && (req_size == 2'b10)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        // Sub-word store parks the merged word in wdata_q for the following write.
        if (we_q) begin
          wdata_d = merged;
          state_d = WR;
        end else begin
          rdata_d = ld_val;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      WR: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign mem_read       = (state_q == RD);
  assign mem_write      = (state_q == WR);
  assign mem_address    = {2'b00, addr_q[31:2]};
  assign mem_write_data = wdata_q;
  assign resp_valid     = (state_q == DONE);
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;

endmodule
